// File: rtl/vga_capture.sv
// VGA sink monitor: recovers sync timing, measures line/frame geometry, tracks
// lock against nominal timing, checksums active pixels and samples a probe pixel.
module vga_capture #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines,
    output logic [10:0] active_w,
    output logic [10:0] active_h,
    output logic [15:0] frame_checksum,
    output logic        frame_done,
    output logic        locked,
    output logic [23:0] probe_rgb,
    output logic        probe_hit
);

    localparam logic [10:0] H_TOTAL_C  = H_TOTAL[10:0];
    localparam logic [10:0] H_ACTIVE_C = H_ACTIVE[10:0];
    localparam logic [10:0] V_TOTAL_C  = V_TOTAL[10:0];
    localparam logic [10:0] V_ACTIVE_C = V_ACTIVE[10:0];
    localparam logic [10:0] TIMEOUT_C  = 11'(2 * H_TOTAL);
    localparam logic [4:0]  LOCK_C     = LOCK_FRAMES[4:0];
    localparam logic [10:0] CNT_MAX    = 11'h7ff;

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  good_cnt_reg, good_cnt_next;

    logic        hs_q, vs_q, bl_q, hs_d, vs_d;
    logic [23:0] rgb_q;
    logic [9:0]  px_in_q, py_in_q, px_reg, py_reg;
    logic [10:0] h_cnt_reg, act_x_reg, v_cnt_reg, act_y_reg;
    logic        line_active_reg, bad_line_reg, hs_seen_reg, vs_seen_reg;
    logic [15:0] chk_reg;

    logic        hs_edge, vs_edge, timeout, line_bad_now, good_frame;
    logic [10:0] h_len, lines_now, act_h_now;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? v : v + 11'd1;
    endfunction

    assign hs_edge = hs_d & ~hs_q;
    assign vs_edge = vs_d & ~vs_q;
    assign timeout = (h_cnt_reg == TIMEOUT_C);
    assign locked  = (state_reg == LOCKED);

    // Line bookkeeping of a coincident hs_edge is folded in before judging the frame.
    always_comb begin
        h_len        = sat_inc(h_cnt_reg);
        line_bad_now = hs_edge && ((h_len != H_TOTAL_C) ||
                       (line_active_reg && (act_x_reg != H_ACTIVE_C)));
        lines_now    = hs_edge ? sat_inc(v_cnt_reg) : v_cnt_reg;
        act_h_now    = (hs_edge && line_active_reg) ? sat_inc(act_y_reg) : act_y_reg;
        good_frame   = vs_seen_reg && !(bad_line_reg || line_bad_now) &&
                       (lines_now == V_TOTAL_C) && (act_h_now == V_ACTIVE_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q            <= 1'b0;
            vs_q            <= 1'b0;
            bl_q            <= 1'b0;
            hs_d            <= 1'b0;
            vs_d            <= 1'b0;
            rgb_q           <= '0;
            px_in_q         <= '0;
            py_in_q         <= '0;
            px_reg          <= '0;
            py_reg          <= '0;
            h_cnt_reg       <= '0;
            act_x_reg       <= '0;
            v_cnt_reg       <= '0;
            act_y_reg       <= '0;
            line_active_reg <= 1'b0;
            bad_line_reg    <= 1'b0;
            hs_seen_reg     <= 1'b0;
            vs_seen_reg     <= 1'b0;
            chk_reg         <= '0;
            line_len        <= '0;
            frame_lines     <= '0;
            active_w        <= '0;
            active_h        <= '0;
            frame_checksum  <= '0;
            frame_done      <= 1'b0;
            probe_rgb       <= '0;
            probe_hit       <= 1'b0;
        end else begin
            hs_q       <= hsync;
            vs_q       <= vsync;
            bl_q       <= blank;
            rgb_q      <= {vga_r, vga_g, vga_b};
            px_in_q    <= probe_x;
            py_in_q    <= probe_y;
            hs_d       <= hs_q;
            vs_d       <= vs_q;
            frame_done <= vs_edge;
            probe_hit  <= 1'b0;

            if (hs_edge) begin
                h_cnt_reg       <= '0;
                act_x_reg       <= '0;
                line_active_reg <= 1'b0;
                hs_seen_reg     <= 1'b1;
                if (hs_seen_reg)
                    line_len <= h_len;
                if (line_active_reg)
                    active_w <= act_x_reg;
            end else begin
                h_cnt_reg <= sat_inc(h_cnt_reg);
                if (bl_q) begin
                    act_x_reg       <= sat_inc(act_x_reg);
                    line_active_reg <= 1'b1;
                end
            end

            if (vs_edge) begin
                frame_lines    <= lines_now;
                active_h       <= act_h_now;
                frame_checksum <= chk_reg;
                v_cnt_reg      <= '0;
                act_y_reg      <= '0;
                bad_line_reg   <= 1'b0;
                chk_reg        <= '0;
                px_reg         <= px_in_q;
                py_reg         <= py_in_q;
                vs_seen_reg    <= 1'b1;
            end else begin
                if (hs_edge)
                    v_cnt_reg <= sat_inc(v_cnt_reg);
                if (hs_edge && line_active_reg)
                    act_y_reg <= sat_inc(act_y_reg);
                if (line_bad_now)
                    bad_line_reg <= 1'b1;
                if (bl_q)
                    chk_reg <= {chk_reg[14:0], chk_reg[15]} ^ rgb_q[23:8] ^ {8'h00, rgb_q[7:0]};
            end

            // A lost sync forgets frame history so the next frame is treated as the first.
            if (timeout)
                vs_seen_reg <= 1'b0;

            if (bl_q && (act_x_reg == {1'b0, px_reg}) && (act_y_reg == {1'b0, py_reg})) begin
                probe_rgb <= rgb_q;
                probe_hit <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= UNLOCKED;
            good_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            good_cnt_reg <= good_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        good_cnt_next = good_cnt_reg;
        if (timeout) begin
            state_next    = UNLOCKED;
            good_cnt_next = '0;
        end else if (vs_edge) begin
            case (state_reg)
                UNLOCKED: begin
                    if (good_frame) begin
                        good_cnt_next = 4'd1;
                        state_next    = (LOCK_C == 5'd1) ? LOCKED : ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (good_frame) begin
                        good_cnt_next = good_cnt_reg + 4'd1;
                        if (({1'b0, good_cnt_reg} + 5'd1) >= LOCK_C)
                            state_next = LOCKED;
                    end else begin
                        state_next    = UNLOCKED;
                        good_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    if (!good_frame) begin
                        state_next    = UNLOCKED;
                        good_cnt_next = '0;
                    end
                end
                default: begin
                    state_next    = UNLOCKED;
                    good_cnt_next = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Frame-level directed bench for vga_capture with a reduced 10x6 timing.
module tb_vga_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsync = 1'b1, vsync = 1'b1, blank = 1'b0;
    logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic [9:0]  probe_x = 10'd3, probe_y = 10'd2;
    logic [10:0] line_len, frame_lines, active_w, active_h;
    logic [15:0] frame_checksum;
    logic        frame_done, locked, probe_hit;
    logic [23:0] probe_rgb;

    int checks = 0;
    int errors = 0;
    int hit_cnt = 0;
    int done_cnt = 0;

    vga_capture #(
        .H_TOTAL(10), .H_ACTIVE(4), .V_TOTAL(6), .V_ACTIVE(3), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank(blank),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .probe_x(probe_x), .probe_y(probe_y),
        .line_len(line_len), .frame_lines(frame_lines), .active_w(active_w),
        .active_h(active_h), .frame_checksum(frame_checksum), .frame_done(frame_done),
        .locked(locked), .probe_rgb(probe_rgb), .probe_hit(probe_hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (probe_hit) hit_cnt++;
        if (frame_done) done_cnt++;
    end

    typedef struct {
        logic [23:0] pix;
        int          gap;
        int          extra;
        bit          vs_mid;
        logic [10:0] e_len, e_lines, e_aw, e_ah;
        logic [15:0] e_chk;
        logic        e_lock;
        logic [23:0] e_probe;
    } frame_t;

    frame_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic v, input logic b, input logic [23:0] rgb);
        @(negedge clk);
        hsync = h;
        vsync = v;
        blank = b;
        {vga_r, vga_g, vga_b} = rgb;
    endtask

    // Line layout: active c0..3 on lines 0..2, hsync low at c6, vsync falls at c6 or c8 of line 4.
    task automatic drive_line(input int line, input int ncl, input int vsp, input logic [23:0] pix);
        for (int c = 0; c < ncl; c++) begin
            drive(c != 6,
                  !((line == 4 && c >= vsp) || (line == 5 && c < vsp)),
                  (line < 3) && (c < 4),
                  (line == 2 && c == 3) ? pix : 24'h0);
        end
    endtask

    task automatic run_frame(input int idx, input frame_t f);
        int h0, d0;
        h0 = hit_cnt;
        d0 = done_cnt;
        for (int g = 0; g < f.gap; g++) begin
            drive(1'b1, 1'b1, 1'b0, 24'h0);
            if (g == 4) check("lock_before_timeout", 32'(locked), 32'd1);
        end
        if (f.gap > 0) check("lock_after_timeout", 32'(locked), 32'd0);
        for (int l = 0; l < 6; l++)
            drive_line(l, (l == 4) ? 10 + f.extra : 10, f.vs_mid ? 8 : 6, f.pix);
        check("line_len", 32'(line_len), 32'(f.e_len));
        check("frame_lines", 32'(frame_lines), 32'(f.e_lines));
        check("active_w", 32'(active_w), 32'(f.e_aw));
        check("active_h", 32'(active_h), 32'(f.e_ah));
        check("frame_checksum", 32'(frame_checksum), 32'(f.e_chk));
        check("locked", 32'(locked), 32'(f.e_lock));
        check("probe_rgb", 32'(probe_rgb), 32'(f.e_probe));
        check("probe_hit_count", 32'(hit_cnt - h0), 32'd1);
        check("frame_done_count", 32'(done_cnt - d0), 32'd1);
        $display("frame %0d: len=%0d lines=%0d aw=%0d ah=%0d chk=%h locked=%0b probe=%h",
                 idx, line_len, frame_lines, active_w, active_h, frame_checksum, locked, probe_rgb);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_line_len"}, 32'(line_len), 32'd0);
        check({tag, "_frame_lines"}, 32'(frame_lines), 32'd0);
        check({tag, "_active_wh"}, {10'd0, active_w, active_h}, 32'd0);
        check({tag, "_checksum"}, 32'(frame_checksum), 32'd0);
        check({tag, "_flags"}, {29'd0, frame_done, locked, probe_hit}, 32'd0);
        check({tag, "_probe_rgb"}, 32'(probe_rgb), 32'd0);
    endtask

    task automatic mid_reset();
        drive_line(0, 10, 6, 24'h0);
        drive_line(1, 10, 6, 24'h0);
        drive_line(2, 10, 6, 24'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 24'h0);
        rst = 1'b1;
        $display("mid-frame reset applied and released");
    endtask

    initial begin
        //                 pix        gap ext mid len    lines  aw    ah    chk       lk    probe
        tbl[0]  = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd5, 11'd4, 11'd3, 16'h0000, 1'b0, 24'h0};
        tbl[1]  = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b0, 24'h0};
        tbl[2]  = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b1, 24'h0};
        tbl[3]  = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b1, 24'h0};
        tbl[4]  = '{24'h123456, 0, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h1262, 1'b1, 24'h123456};
        tbl[5]  = '{24'h123456, 0, 0, 1'b1, 11'd10, 11'd6, 11'd4, 11'd3, 16'h1262, 1'b1, 24'h123456};
        tbl[6]  = '{24'h0,      0, 1, 1'b0, 11'd11, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b1, 24'h0};
        tbl[7]  = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b0, 24'h0};
        tbl[8]  = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b0, 24'h0};
        tbl[9]  = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b1, 24'h0};
        tbl[10] = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b1, 24'h0};
        tbl[11] = '{24'h0,     25, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b0, 24'h0};
        tbl[12] = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b0, 24'h0};
        tbl[13] = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b1, 24'h0};
        tbl[14] = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd5, 11'd4, 11'd3, 16'h0000, 1'b0, 24'h0};
        tbl[15] = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b0, 24'h0};
        tbl[16] = '{24'h0,      0, 0, 1'b0, 11'd10, 11'd6, 11'd4, 11'd3, 16'h0000, 1'b1, 24'h0};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            if (i == 14) mid_reset();
            run_frame(i, tbl[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Sink end of the VGA output: consumes hsync, vsync, blank and RGB exactly as driven toward the DAC.
- Recovers timing and measures line and frame geometry against nominal parameters.
- Declares lock and computes a per-frame checksum of active pixels.
- Samples one probe pixel per frame. Used on-chip for loopback self-test of the display path and as a bench monitor.

Parameters:
- H_TOTAL, 800, nominal clocks per line (≤1023)
- H_ACTIVE, 640, nominal active pixels per line
- V_TOTAL, 525, nominal lines per frame
- V_ACTIVE, 480, nominal active lines per frame
- LOCK_FRAMES, 2, consecutive good frames needed to declare lock (1..15)

Ports:
- clk  in  1  pixel clock; one pixel per cycle
- rst  in  1  asynchronous, active-low reset
- hsync  in  1  horizontal sync, active-low
- vsync  in  1  vertical sync, active-low
- blank  in  1  low = blanking, high = active pixel
- vga_r, vga_g, vga_b  in  8 each  pixel colour
- probe_x, probe_y  in  10 each  active-pixel coordinate to sample
- line_len  out  11  clocks between last two hsync falling edges
- frame_lines  out  11  hsync edges in last complete frame
- active_w  out  11  active pixels in last active line
- active_h  out  11  active lines in last frame
- frame_checksum  out  16  checksum of last frame
- frame_done  out  1  one-cycle pulse per frame boundary
- locked  out  1  timing matches parameters
- probe_rgb  out  24  {r,g,b} captured at probe coordinate
- probe_hit  out  1  one-cycle pulse when probe_rgb updates

Behaviour:
- Reset (rst low, async): all outputs 0, all counters and flags 0, state UNLOCKED.
- Stage 0: all inputs registered once.
- Edge detection: on the registered copy versus its one-cycle delay; hs_edge / vs_edge = 1→0 transition.
- Output timing: all outputs update on the 2nd rising clk edge after the first edge sampling the new input level.
- h_cnt (11b): cleared to 0 on hs_edge, else +1, saturating at 2047.
  - On hs_edge, if a prior hs_edge was seen since reset: line_len <= h_cnt+1.
  - Set bad_line if h_cnt+1 ≠ H_TOTAL.
- act_x: cleared on hs_edge; +1 per cycle with registered blank high.
  - On hs_edge, if line_active: active_w <= act_x; set bad_line if act_x ≠ H_ACTIVE.
- v_cnt: +1 on hs_edge alone.
  - On vs_edge: frame_lines <= v_cnt + (hs_edge ? 1 : 0), then v_cnt <= 0.
- act_y: +1 on hs_edge if line_active (the line had ≥1 active cycle); cleared on vs_edge.
  - On vs_edge: active_h <= act_y, or act_y+1 if a coincident hs_edge closes an active line.
- Checksum: on each active cycle, chk <= rotl1(chk) XOR {r,g} XOR {8'h00,b}.
  - On vs_edge: frame_checksum <= chk, chk <= 0.
- Probe: probe_x/probe_y latched on vs_edge.
  - On an active cycle with act_x == px and act_y == py: probe_rgb <= {r,g,b}, probe_hit pulses.
  - No hit in a frame → probe_rgb holds its old value.
- frame_done: pulses on every vs_edge, including the first.
- Good frame at vs_edge requires all of:
  - not the first vs_edge since reset or since timeout;
  - no bad_line during the frame;
  - frame_lines == V_TOTAL;
  - active_h == V_ACTIVE.
- bad_line is cleared at each vs_edge.
- Lock FSM (evaluated at vs_edge; good_cnt 4b):
  - UNLOCKED: good frame → ACQUIRE with good_cnt=1, or straight to LOCKED if LOCK_FRAMES=1.
  - ACQUIRE: good frame → good_cnt+1; LOCKED when good_cnt reaches LOCK_FRAMES. Bad frame → UNLOCKED, good_cnt=0.
  - LOCKED: bad frame → UNLOCKED.
  - locked = (state == LOCKED).
- Timeout: h_cnt reaching 2*H_TOTAL in any state → UNLOCKED, good_cnt=0, first-frame flag set again. Measurement outputs hold.
- Simultaneous hs_edge and vs_edge: hs_edge line bookkeeping (line_len, active_w, bad_line) is applied first, then the frame is evaluated.

Test Plan:
- Params H_TOTAL=10, H_ACTIVE=4, V_TOTAL=6, V_ACTIVE=3, LOCK_FRAMES=2; 4 ideal frames, all-zero RGB.
  - locked rises at the 3rd vs_edge (+2 cycles).
  - line_len=10, frame_lines=6, active_w=4, active_h=3, frame_checksum=0x0000.
- Same timing; single nonzero pixel r=0x12, g=0x34, b=0x56 at the last active pixel (x=3, y=2).
  - frame_checksum=0x1262.
  - With probe (3,2): probe_rgb=0x123456, probe_hit pulses once per frame.
- Locked, then one line of 11 clocks.
  - line_len=11 for that line; locked falls at the next frame_done.
  - Relock after 2 further good frames.
- Locked, then hsync held high for 20 clocks.
  - locked falls when h_cnt reaches 20; the next vs_edge frame is not counted good.
- rst asserted mid-frame.
  - All outputs 0 immediately (asynchronous).
  - After release, the first frame_done yields no lock; lock follows after 2 good frames.
- vsync falling edge coincident with hsync falling edge vs. vsync falling mid-line.
  - frame_lines=6 in both cases.
